// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard: default sizes,
// forwarding-select encoding and the select-width helper.
package hazard_scoreboard_pkg;
   localparam int NREG_DEF     = 32;
   localparam int RADDR_W_DEF  = 5;
   localparam int NSRC_DEF     = 2;
   localparam int NFWD_DEF     = 2;
   localparam int CNT_W_DEF    = 2;
   localparam int FSEL_REGFILE = 0;

   // Width of one forwarding select: regfile plus one code per bypass stage.
   function automatic int fsel_w(input int nfwd);
      return $clog2(nfwd + 1);
   endfunction
endpackage

// File: rtl/sb_src_check.sv
// One source operand: looks up its pending-write counter, scans the bypass
// stages youngest first and produces the forwarding select or a stall.
module sb_src_check
   import hazard_scoreboard_pkg::*;
#(
   parameter int NREG    = NREG_DEF,
   parameter int RADDR_W = RADDR_W_DEF,
   parameter int NFWD    = NFWD_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int FSEL_W  = fsel_w(NFWD_DEF)
) (
   input  logic                    live,
   input  logic [RADDR_W-1:0]      src_addr,
   input  logic [NREG*CNT_W-1:0]   cnt_flat,
   input  logic [NFWD-1:0]         fwd_valid,
   input  logic [NFWD*RADDR_W-1:0] fwd_addr,
   input  logic [NFWD-1:0]         fwd_ready,
   output logic [FSEL_W-1:0]       fwd_sel,
   output logic                    stall
);
   logic [CNT_W-1:0] cnt_val;
   logic             hit;

   assign cnt_val = cnt_flat[int'(src_addr)*CNT_W +: CNT_W];

   // NOTE: every output and temporary gets a default before any branch, so no
   // path through this block leaves a value held and no latch is inferred.
   always_comb begin
      fwd_sel = FSEL_W'(FSEL_REGFILE);
      stall   = 1'b0;
      hit     = 1'b0;
      if (live && cnt_val != '0) begin
         for (int k = 0; k < NFWD; k++) begin
            if (!hit && fwd_valid[k] && fwd_addr[k*RADDR_W +: RADDR_W] == src_addr) begin
               hit = 1'b1;
               if (fwd_ready[k]) fwd_sel = FSEL_W'(k + 1);
               else              stall   = 1'b1;
            end
         end
         // Writer is pending but sits in no bypassable stage (e.g. divider).
         if (!hit) stall = 1'b1;
      end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register pending-write counters, per-source
// bypass selection and stall generation, plus sticky error and stall stats.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int  NREG    = NREG_DEF,
   parameter int  RADDR_W = RADDR_W_DEF,
   parameter int  NSRC    = NSRC_DEF,
   parameter int  NFWD    = NFWD_DEF,
   parameter int  CNT_W   = CNT_W_DEF,
   localparam int FSEL_W  = fsel_w(NFWD)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ds_valid,
   input  logic [NSRC-1:0]         ds_src_en,
   input  logic [NSRC*RADDR_W-1:0] ds_src_addr,
   input  logic                    ds_dst_we,
   input  logic [RADDR_W-1:0]      ds_dst_addr,
   input  logic                    issue_fire,
   input  logic [NFWD-1:0]         fwd_valid,
   input  logic [NFWD*RADDR_W-1:0] fwd_addr,
   input  logic [NFWD-1:0]         fwd_ready,
   input  logic                    wb_fire,
   input  logic [RADDR_W-1:0]      wb_addr,
   input  logic                    flush,
   output logic                    is_stall,
   output logic [NSRC*FSEL_W-1:0]  fwd_sel,
   output logic                    sb_err,
   output logic [31:0]             stall_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]      cnt [NREG];
   logic [NREG*CNT_W-1:0] cnt_flat;
   logic [NSRC-1:0]       src_live;
   logic [NSRC-1:0]       src_stall;
   logic                  dst_full;
   logic                  inc_ok;
   logic [NREG-1:0]       inc_vec;
   logic [NREG-1:0]       dec_vec;
   logic                  err_evt;

   always_comb begin
      cnt_flat = '0;
      for (int r = 0; r < NREG; r++) cnt_flat[r*CNT_W +: CNT_W] = cnt[r];
   end

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      assign src_live[i] = ds_valid && ds_src_en[i] &&
                           (ds_src_addr[i*RADDR_W +: RADDR_W] != '0);

      sb_src_check #(
         .NREG    (NREG),
         .RADDR_W (RADDR_W),
         .NFWD    (NFWD),
         .CNT_W   (CNT_W),
         .FSEL_W  (FSEL_W)
      ) u_src_check (
         .live      (src_live[i]),
         .src_addr  (ds_src_addr[i*RADDR_W +: RADDR_W]),
         .cnt_flat  (cnt_flat),
         .fwd_valid (fwd_valid),
         .fwd_addr  (fwd_addr),
         .fwd_ready (fwd_ready),
         .fwd_sel   (fwd_sel[i*FSEL_W +: FSEL_W]),
         .stall     (src_stall[i])
      );
   end

   // A saturated destination counter must hold ID rather than wrap.
   assign dst_full = ds_valid && ds_dst_we && (ds_dst_addr != '0) &&
                     (cnt[ds_dst_addr] == CNT_MAX);
   assign is_stall = (|src_stall) || dst_full;
   assign inc_ok   = issue_fire && !is_stall && ds_dst_we;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      err_evt = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         inc_vec[r] = inc_ok  && (ds_dst_addr == RADDR_W'(r));
         dec_vec[r] = wb_fire && (wb_addr     == RADDR_W'(r));
         if (dec_vec[r] && !inc_vec[r] && cnt[r] == '0)     err_evt = 1'b1;
         if (inc_vec[r] && !dec_vec[r] && cnt[r] == CNT_MAX) err_evt = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the counter array is reset explicitly because a mid-run reset
         // must drop every pending write; it cannot map onto plain RAM.
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
         sb_err    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (ds_valid && is_stall) stall_cnt <= stall_cnt + 32'd1;
         if (flush) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
         end else begin
            for (int r = 0; r < NREG; r++) begin
               if (inc_vec[r] && !dec_vec[r] && cnt[r] != CNT_MAX)
                  cnt[r] <= cnt[r] + 1'b1;
               else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
                  cnt[r] <= cnt[r] - 1'b1;
            end
            if (err_evt) sb_err <= 1'b1;
         end
      end
   end
endmodule
